// File: rtl/mem_access_master_if.sv
// mem_access_master_if: command, response and memory-pin bundle shared by
// the access master and whatever sits on the other side of it.
interface mem_access_master_if;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [3:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic        renable, wenable, valid_out;
    logic [3:0]  addr;
    logic [31:0] data_in, data_out;
    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, data_out, valid_out,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, renable, wenable, addr, data_in
    );
    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, data_out, valid_out,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, renable, wenable, addr, data_in
    );
endinterface

// File: rtl/mem_access_master.sv
// mem_access_master: single-command initiator for the 16x32 memory with
// read timeout and sticky detection of unsolicited valid_out pulses.
module mem_access_master #(
    parameter int TIMEOUT_CYCLES = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    mem_access_master_if.master        bus,
    output logic                       stray_valid
);
    typedef enum logic [2:0] {IDLE, WRITE, READ_REQ, READ_WAIT, RESP} state_t;
    localparam logic [7:0] lim = 8'(TIMEOUT_CYCLES);
    state_t state, state_nxt;
    logic [7:0] cnt;
    logic done;
    // valid_out is checked first so a response on the limit cycle still succeeds
    assign done = state == READ_WAIT && (bus.valid_out || cnt == lim);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (bus.cmd_valid) state_nxt = bus.cmd_write ? WRITE : READ_REQ;
            WRITE:     state_nxt = IDLE;
            READ_REQ:  state_nxt = READ_WAIT;
            READ_WAIT: if (done) state_nxt = RESP;
            RESP:      if (bus.rsp_ready) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end
    always_comb begin
        bus.cmd_ready = state == IDLE;
        bus.rsp_valid = state == RESP;
        bus.renable   = state == READ_REQ;
        bus.wenable   = state == WRITE;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.addr      <= '0;
            bus.data_in   <= '0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
            cnt           <= '0;
            stray_valid   <= 1'b0;
        end else begin
            if (state == IDLE && bus.cmd_valid) begin
                bus.addr    <= bus.cmd_addr;
                bus.data_in <= bus.cmd_wdata;
            end
            cnt <= (state == READ_WAIT && !done) ? cnt + 8'd1 : 8'd0;
            if (done) begin
                bus.rsp_rdata <= bus.valid_out ? bus.data_out : 32'd0;
                bus.rsp_err   <= !bus.valid_out;
            end
            if (bus.valid_out && state != READ_WAIT) stray_valid <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_access_master.sv
// tb_mem_access_master: directed sequence with a response scoreboard and a
// latency-programmable memory responder.
module tb_mem_access_master;
    localparam int T = 8;
    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic stray_valid;
    rsp_t sb[$];
    logic [31:0] ref_mem [16];
    logic [31:0] mem [16];
    int lat = 1;
    int stray_req = 0;
    int pass_cnt = 0;
    int total = 0;
    int cd = 0;
    logic [3:0] ma = '0;

    mem_access_master_if bus();
    mem_access_master #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst), .bus(bus), .stray_valid(stray_valid)
    );

    always #5 clk = ~clk;

    // memory: stores on wenable, answers lat cycles after renable (lat=0: never)
    initial begin
        bus.valid_out = 1'b0;
        bus.data_out  = '0;
        forever begin
            @(posedge clk); #1;
            bus.valid_out = 1'b0;
            if (stray_req != 0) begin
                bus.valid_out = 1'b1;
                bus.data_out  = 32'hFFFF_FFFF;
                stray_req = 0;
            end
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    bus.valid_out = 1'b1;
                    bus.data_out  = mem[ma];
                end
            end
            if (bus.renable && lat > 0) begin
                cd = lat;
                ma = bus.addr;
            end
            if (bus.wenable) mem[bus.addr] = bus.data_in;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_cmd_ready"}, bus.cmd_ready, 1);
        chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
        chk({tag, "_rsp_rdata"}, bus.rsp_rdata, 0);
        chk({tag, "_rsp_err"}, bus.rsp_err, 0);
        chk({tag, "_renable"}, bus.renable, 0);
        chk({tag, "_wenable"}, bus.wenable, 0);
        chk({tag, "_addr"}, bus.addr, 0);
        chk({tag, "_data_in"}, bus.data_in, 0);
        chk({tag, "_stray"}, stray_valid, 0);
    endtask

    // returns in the cycle after acceptance
    task automatic send(input logic wr, input logic [3:0] a, input logic [31:0] d);
        int n = 0;
        rsp_t e;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        while (!bus.cmd_ready && n < 20) begin
            tick();
            n++;
        end
        chk("cmd_accept", bus.cmd_ready, 1);
        tick();
        bus.cmd_valid = 1'b0;
        if (wr) ref_mem[a] = d;
        else begin
            e.err   = (lat == 0 || lat > T + 1);
            e.rdata = e.err ? 32'd0 : ref_mem[a];
            sb.push_back(e);
        end
    endtask

    task automatic wait_rsp(input int exp_n, input string tag);
        int n = 1;
        rsp_t e;
        while (!bus.rsp_valid && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, n, exp_n);
        e = sb.pop_front();
        chk({tag, "_valid"}, bus.rsp_valid, 1);
        chk({tag, "_rdata"}, bus.rsp_rdata, e.rdata);
        chk({tag, "_err"}, bus.rsp_err, e.err);
    endtask

    task automatic ack(input string tag);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        chk({tag, "_ack_rsp_valid"}, bus.rsp_valid, 0);
        chk({tag, "_ack_idle"}, bus.cmd_ready, 1);
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_checks("reset");
        rst = 1'b1;
        tick();

        send(1'b1, 4'h3, 32'hDEAD_BEEF);
        chk("wr_wenable", bus.wenable, 1);
        chk("wr_addr", bus.addr, 32'h3);
        chk("wr_data_in", bus.data_in, 32'hDEAD_BEEF);
        chk("wr_cmd_ready", bus.cmd_ready, 0);
        tick();
        chk("wr_wenable_off", bus.wenable, 0);
        chk("wr_cmd_ready_back", bus.cmd_ready, 1);

        lat = 1;
        send(1'b0, 4'h3, 32'h0);
        chk("rd_renable", bus.renable, 1);
        chk("rd_addr", bus.addr, 32'h3);
        wait_rsp(3, "rd");
        ack("rd");

        lat = 0;
        send(1'b0, 4'h5, 32'h0);
        wait_rsp(T + 3, "timeout");
        ack("timeout");

        send(1'b1, 4'hF, 32'h1234_5678);
        lat = 1;
        send(1'b0, 4'hF, 32'h0);
        wait_rsp(3, "bp");
        repeat (5) begin
            tick();
            chk("bp_hold_valid", bus.rsp_valid, 1);
            chk("bp_hold_rdata", bus.rsp_rdata, 32'h1234_5678);
            chk("bp_hold_cmd_ready", bus.cmd_ready, 0);
        end
        ack("bp");

        send(1'b1, 4'hA, 32'hA5A5_A5A5);
        lat = 8;
        send(1'b0, 4'hA, 32'h0);
        wait_rsp(10, "edge8");
        ack("edge8");
        lat = 9;
        send(1'b0, 4'hA, 32'h0);
        wait_rsp(11, "edge9");
        ack("edge9");
        chk("no_stray_yet", stray_valid, 0);

        stray_req = 1;
        repeat (3) tick();
        chk("stray_set", stray_valid, 1);
        chk("stray_no_rsp", bus.rsp_valid, 0);
        repeat (5) tick();
        chk("stray_sticky", stray_valid, 1);
        chk("stray_idle", bus.cmd_ready, 1);

        lat = 6;
        send(1'b0, 4'h3, 32'h0);
        tick();
        tick();
        chk("midrst_waiting", bus.rsp_valid, 0);
        rst = 1'b0;
        #1;
        reset_checks("midrst");
        void'(sb.pop_front());
        tick();
        rst = 1'b1;
        repeat (5) tick();
        chk("late_valid_stray", stray_valid, 1);
        chk("post_rst_ready", bus.cmd_ready, 1);
        chk("post_rst_no_rsp", bus.rsp_valid, 0);

        send(1'b1, 4'h0, 32'h0BAD_F00D);
        chk("post_wr_wenable", bus.wenable, 1);
        chk("post_wr_addr", bus.addr, 32'h0);
        chk("post_wr_data_in", bus.data_in, 32'h0BAD_F00D);
        lat = 1;
        send(1'b0, 4'h0, 32'h0);
        wait_rsp(3, "post_rd");
        ack("post_rd");

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
